// File: rtl/frame_generator_pkg.sv
// Shared definitions for the AXIS frame generator: FSM encoding, frame-length floor
// and the bit positions of the two counters packed into the result word.
package frame_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int MIN_FRAME_LEN      = 16;
    localparam int RESULT_FIELD_WIDTH = 64;
    localparam int RESULT_BYTES_LSB   = 0;
    localparam int RESULT_FRAMES_LSB  = 64;

    // Byte enables for the final beat of a frame of len bytes.
    function automatic logic [7:0] last_keep(input logic [15:0] len);
        if (len[2:0] == 3'd0) begin
            return 8'hFF;
        end
        return (8'h01 << len[2:0]) - 8'h01;
    endfunction

endpackage

// File: rtl/frame_generator.sv
// AXIS test-frame source: emits runs of fixed-length frames (header, seq/timestamp,
// seq/beat-index payload) with a programmable inter-frame gap and running totals.
module frame_generator
    import frame_generator_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    start,
    input  logic                    stop,
    output logic [127:0]            result,
    input  logic [15:0]             cfg_frame_len,
    input  logic [31:0]             cfg_count,
    input  logic [15:0]             cfg_gap,
    input  logic [63:0]             cfg_header,
    input  logic [ID_WIDTH-1:0]     cfg_id,
    output logic [DATA_WIDTH-1:0]   axis_m_data,
    output logic [DATA_WIDTH/8-1:0] axis_m_keep,
    output logic                    axis_m_last,
    output logic [DATA_WIDTH/8-1:0] axis_m_user,
    output logic [ID_WIDTH-1:0]     axis_m_id,
    output logic                    axis_m_valid,
    input  logic                    axis_m_ready
);

    state_t state_reg, state_next;

    logic [15:0]         len_reg;
    logic [31:0]         count_reg;
    logic [15:0]         gap_reg;
    logic [63:0]         header_reg;
    logic [ID_WIDTH-1:0] id_reg;
    logic [15:0]         last_beat_reg;
    logic [15:0]         beat_reg;
    logic [15:0]         gap_cnt_reg;
    logic [31:0]         seq_reg;
    logic [31:0]         ts_reg;
    logic [31:0]         ts_cap_reg;
    logic [63:0]         frames_reg;
    logic [63:0]         bytes_reg;
    logic                stop_pend_reg;

    logic [15:0] len_eff;
    logic [16:0] beats_eff;
    logic        is_send;
    logic        is_last_beat;
    logic        handshake;
    logic        last_hs;
    logic        count_done;
    logic        stop_now;
    logic [63:0] frames_inc;

    assign len_eff      = (cfg_frame_len < 16'(MIN_FRAME_LEN)) ? 16'(MIN_FRAME_LEN) : cfg_frame_len;
    assign beats_eff    = ({1'b0, len_eff} + 17'd7) >> 3;
    assign is_send      = (state_reg == ST_SEND);
    assign is_last_beat = (beat_reg == last_beat_reg);
    assign handshake    = is_send && axis_m_ready;
    assign last_hs      = handshake && is_last_beat;
    assign frames_inc   = frames_reg + 64'd1;
    assign count_done   = (count_reg != 32'd0) && (frames_inc == {32'd0, count_reg});
    // A stop arriving in the very cycle of the last handshake still ends the run.
    assign stop_now     = stop_pend_reg || stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (last_hs) begin
                    if (stop_now || count_done) begin
                        state_next = ST_IDLE;
                    end else if (gap_reg != 16'd0) begin
                        state_next = ST_GAP;
                    end else begin
                        state_next = ST_SEND;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (gap_cnt_reg == 16'd0) begin
                    state_next = ST_SEND;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg       <= '0;
            count_reg     <= '0;
            gap_reg       <= '0;
            header_reg    <= '0;
            id_reg        <= '0;
            last_beat_reg <= '0;
            beat_reg      <= '0;
            gap_cnt_reg   <= '0;
            seq_reg       <= '0;
            ts_reg        <= '0;
            ts_cap_reg    <= '0;
            frames_reg    <= '0;
            bytes_reg     <= '0;
            stop_pend_reg <= 1'b0;
        end else begin
            ts_reg <= ts_reg + 32'd1;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        len_reg       <= len_eff;
                        count_reg     <= cfg_count;
                        gap_reg       <= cfg_gap;
                        header_reg    <= cfg_header;
                        id_reg        <= cfg_id;
                        last_beat_reg <= 16'(beats_eff - 17'd1);
                        beat_reg      <= '0;
                        seq_reg       <= '0;
                        ts_reg        <= '0;
                        ts_cap_reg    <= '0;
                        frames_reg    <= '0;
                        bytes_reg     <= '0;
                        stop_pend_reg <= stop;
                    end
                end
                ST_SEND: begin
                    if (stop) begin
                        stop_pend_reg <= 1'b1;
                    end
                    if (last_hs) begin
                        beat_reg   <= '0;
                        frames_reg <= frames_inc;
                        bytes_reg  <= bytes_reg + {48'd0, len_reg};
                        seq_reg    <= seq_reg + 32'd1;
                        gap_cnt_reg <= gap_reg - 16'd1;
                        // Timestamp is the run-counter value in the cycle the next beat 0 appears.
                        ts_cap_reg <= ts_reg + 32'd1;
                    end else if (handshake) begin
                        beat_reg <= beat_reg + 16'd1;
                    end
                end
                ST_GAP: begin
                    gap_cnt_reg <= gap_cnt_reg - 16'd1;
                    ts_cap_reg  <= ts_reg + 32'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        axis_m_data  = '0;
        axis_m_keep  = '0;
        axis_m_last  = 1'b0;
        axis_m_id    = '0;
        axis_m_valid = is_send;
        if (is_send) begin
            axis_m_id   = id_reg;
            axis_m_last = is_last_beat;
            axis_m_keep = is_last_beat ? last_keep(len_reg) : 8'hFF;
            if (beat_reg == 16'd0) begin
                axis_m_data = header_reg;
            end else if (beat_reg == 16'd1) begin
                axis_m_data = {seq_reg, ts_cap_reg};
            end else begin
                axis_m_data = {seq_reg, 16'd0, beat_reg};
            end
        end
    end

    assign axis_m_user = '0;
    assign ready       = (state_reg == ST_IDLE);
    assign result      = {frames_reg, bytes_reg};

endmodule

// File: tb/tb_frame_generator.sv
// Scoreboard bench for frame_generator: expected beats are queued at run start and
// popped on every handshake; per-scenario tasks check totals, gaps and reset behaviour.
module tb_frame_generator;
    import frame_generator_pkg::*;

    logic         clk;
    logic         rst;
    logic         ready;
    logic         start;
    logic         stop;
    logic [127:0] result;
    logic [15:0]  cfg_frame_len;
    logic [31:0]  cfg_count;
    logic [15:0]  cfg_gap;
    logic [63:0]  cfg_header;
    logic [2:0]   cfg_id;
    logic [63:0]  axis_m_data;
    logic [7:0]   axis_m_keep;
    logic         axis_m_last;
    logic [7:0]   axis_m_user;
    logic [2:0]   axis_m_id;
    logic         axis_m_valid;
    logic         axis_m_ready;

    frame_generator #(.DATA_WIDTH(64), .ID_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .ready(ready), .start(start), .stop(stop), .result(result),
        .cfg_frame_len(cfg_frame_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
        .cfg_header(cfg_header), .cfg_id(cfg_id),
        .axis_m_data(axis_m_data), .axis_m_keep(axis_m_keep), .axis_m_last(axis_m_last),
        .axis_m_user(axis_m_user), .axis_m_id(axis_m_id), .axis_m_valid(axis_m_valid),
        .axis_m_ready(axis_m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        is_ts;
    } beat_t;

    beat_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    longint      cyc = 0;
    longint      start_cyc = 0;
    logic [31:0] ts_exp = '0;
    bit          fresh = 0;
    bit          stalled = 0;
    logic [63:0] held_data = '0;
    logic [7:0]  held_keep = '0;
    logic        held_last = 1'b0;
    int          sb_frames = 0;
    int          sb_beat = 0;

    // Queue the beats of nfr frames of length len (seq numbering from 0).
    task automatic push_frames(input int len, input int nfr, input logic [63:0] hdr);
        int    l;
        int    nb;
        int    r;
        beat_t it;
        l  = (len < 16) ? 16 : len;
        nb = (l + 7) / 8;
        r  = l % 8;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < nb; k++) begin
                if (k == 0)      it.data = hdr;
                else if (k == 1) it.data = {f[31:0], 32'h0};
                else             it.data = {f[31:0], k[31:0]};
                it.is_ts = (k == 1);
                it.last  = (k == nb - 1);
                it.keep  = (it.last && r != 0) ? 8'((1 << r) - 1) : 8'hFF;
                sb.push_back(it);
            end
        end
    endtask

    // One clock: drive inputs just after the edge, observe on the falling edge and
    // consume the scoreboard on every handshake.
    task automatic step(input logic s, input logic p, input logic r);
        beat_t       it;
        logic [63:0] exp_data;
        @(posedge clk);
        #1;
        start = s;
        stop = p;
        axis_m_ready = r;
        @(negedge clk);
        cyc++;
        if (start && ready && !rst) begin
            start_cyc = cyc + 1;
            fresh = 1;
        end
        if (stalled) begin
            checks++;
            if (!axis_m_valid || axis_m_data !== held_data || axis_m_keep !== held_keep || axis_m_last !== held_last) begin
                failures++;
                $display("FAIL stall_hold: got valid=%b data=%h keep=%h last=%b, required valid=1 data=%h keep=%h last=%b",
                         axis_m_valid, axis_m_data, axis_m_keep, axis_m_last, held_data, held_keep, held_last);
            end
        end
        if (axis_m_valid && fresh) begin
            ts_exp = 32'(cyc - start_cyc);
            fresh = 0;
        end
        if (axis_m_valid && axis_m_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: got data=%h last=%b, required no beat", axis_m_data, axis_m_last);
            end else begin
                it = sb.pop_front();
                exp_data = it.is_ts ? {it.data[63:32], ts_exp} : it.data;
                if (axis_m_data !== exp_data || axis_m_keep !== it.keep || axis_m_last !== it.last ||
                    axis_m_id !== cfg_id || axis_m_user !== 8'h00) begin
                    failures++;
                    $display("FAIL beat f%0d b%0d: got data=%h keep=%h last=%b id=%0d user=%h, required data=%h keep=%h last=%b id=%0d user=00",
                             sb_frames, sb_beat, axis_m_data, axis_m_keep, axis_m_last, axis_m_id, axis_m_user,
                             exp_data, it.keep, it.last, cfg_id);
                end else begin
                    $display("beat f%0d b%0d data=%h keep=%h last=%b ok", sb_frames, sb_beat, axis_m_data, axis_m_keep, axis_m_last);
                end
                sb_beat++;
                if (it.last) begin
                    fresh = 1;
                    sb_frames++;
                    sb_beat = 0;
                end
            end
        end
        stalled   = axis_m_valid && !axis_m_ready;
        held_data = axis_m_data;
        held_keep = axis_m_keep;
        held_last = axis_m_last;
    endtask

    task automatic begin_run(input int len, input int cnt, input int gap, input logic [63:0] hdr,
                             input logic [2:0] id, input int nfr, input logic stop_too);
        cfg_frame_len = 16'(len);
        cfg_count     = 32'(cnt);
        cfg_gap       = 16'(gap);
        cfg_header    = hdr;
        cfg_id        = id;
        sb_frames = 0;
        sb_beat   = 0;
        push_frames(len, nfr, hdr);
        step(1'b1, stop_too, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic run_to_idle(input int max_cyc, input bit rand_rdy, input string name);
        int n;
        n = 0;
        while (!ready && n < max_cyc) begin
            step(1'b0, 1'b0, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        checks++;
        if (!ready) begin
            failures++;
            $display("FAIL %s_timeout: got ready=0 after %0d cycles, required ready=1", name, n);
        end
    endtask

    task automatic check_result(input string name, input longint frames, input longint bytes);
        checks++;
        if (result[RESULT_FRAMES_LSB +: 64] !== 64'(frames) || result[RESULT_BYTES_LSB +: 64] !== 64'(bytes) ||
            sb.size() != 0) begin
            failures++;
            $display("FAIL %s_result: got frames=%0d bytes=%0d pending=%0d, required frames=%0d bytes=%0d pending=0",
                     name, result[RESULT_FRAMES_LSB +: 64], result[RESULT_BYTES_LSB +: 64], sb.size(), frames, bytes);
        end else begin
            $display("%s result frames=%0d bytes=%0d ok", name, frames, bytes);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        checks++;
        if (ready !== 1'b1 || axis_m_valid !== 1'b0 || axis_m_last !== 1'b0 || axis_m_data !== 64'h0 ||
            axis_m_keep !== 8'h0 || axis_m_user !== 8'h0 || axis_m_id !== 3'h0 || result !== 128'h0) begin
            failures++;
            $display("FAIL reset_state: got ready=%b valid=%b last=%b data=%h keep=%h id=%0d result=%h, required ready=1 and all else 0",
                     ready, axis_m_valid, axis_m_last, axis_m_data, axis_m_keep, axis_m_id, result);
        end else begin
            $display("reset state ok");
        end
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int vcount;
        bit broken;
        vcount = 0;
        broken = 0;
        begin_run(64, 2, 0, 64'hA5A5_0000_1234_5678, 3'd5, 2, 1'b0);
        if (axis_m_valid) vcount++;
        while (!ready && vcount < 40) begin
            step(1'b0, 1'b0, 1'b1);
            if (axis_m_valid) begin
                vcount++;
            end else if (!ready) begin
                broken = 1;
            end
        end
        checks++;
        if (vcount != 16 || broken) begin
            failures++;
            $display("FAIL b2b_contiguous: got valid_beats=%0d bubble=%0d, required 16 and 0", vcount, broken);
        end
        check_result("b2b", 2, 128);
    endtask

    task automatic test_keep_len();
        begin_run(61, 1, 0, 64'h0000_0000_0000_003D, 3'd1, 1, 1'b0);
        run_to_idle(50, 0, "len61");
        check_result("len61", 1, 61);
        begin_run(10, 1, 0, 64'hFFFF_0000_FFFF_000A, 3'd2, 1, 1'b0);
        run_to_idle(50, 0, "len10");
        check_result("len10", 1, 16);
    endtask

    task automatic test_backpressure();
        begin_run(64, 1, 0, 64'hDEAD_BEEF_CAFE_F00D, 3'd7, 1, 1'b0);
        run_to_idle(400, 1, "bp");
        check_result("bp", 1, 64);
    endtask

    task automatic test_stop_gap();
        bit do_stop;
        bit stopped;
        bit in_gap;
        int gap_len;
        int prev_frames;
        int n;
        do_stop = 0;
        stopped = 0;
        in_gap = 0;
        gap_len = 0;
        n = 0;
        begin_run(40, 0, 3, 64'h0123_4567_89AB_CDEF, 3'd3, 6, 1'b0);
        while (!ready && n < 300) begin
            prev_frames = sb_frames;
            step(1'b0, do_stop, 1'b1);
            n++;
            do_stop = 0;
            if (!stopped && sb_frames == 5 && sb_beat == 1) begin
                do_stop = 1;
                stopped = 1;
            end
            if (axis_m_valid && in_gap) begin
                checks++;
                if (gap_len != 3) begin
                    failures++;
                    $display("FAIL gap_len: got %0d idle cycles, required 3", gap_len);
                end else begin
                    $display("gap before frame %0d = %0d cycles ok", sb_frames, gap_len);
                end
                in_gap = 0;
            end else if (!axis_m_valid && in_gap) begin
                gap_len++;
            end
            if (sb_frames != prev_frames) begin
                in_gap = 1;
                gap_len = 0;
            end
        end
        checks++;
        if (!ready || !stopped) begin
            failures++;
            $display("FAIL stop_timeout: got ready=%b stopped=%0d, required ready=1 stopped=1", ready, stopped);
        end
        check_result("stop", 6, 240);
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        begin_run(64, 2, 0, 64'h5555_AAAA_5555_AAAA, 3'd4, 2, 1'b0);
        while (!(sb_frames == 1 && sb_beat == 3) && n < 100) begin
            step(1'b0, 1'b0, 1'b1);
            n++;
        end
        checks++;
        if (result[RESULT_FRAMES_LSB +: 64] !== 64'd1 || result[RESULT_BYTES_LSB +: 64] !== 64'd64) begin
            failures++;
            $display("FAIL midrst_before: got result=%h, required frames=1 bytes=64", result);
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (axis_m_valid !== 1'b0 || ready !== 1'b1 || result !== 128'h0) begin
            failures++;
            $display("FAIL midrst_after: got valid=%b ready=%b result=%h, required valid=0 ready=1 result=0",
                     axis_m_valid, ready, result);
        end else begin
            $display("mid-frame reset ok");
        end
        rst = 1'b0;
        sb.delete();
        fresh = 0;
        stalled = 0;
        begin_run(16, 1, 0, 64'h0F0F_0F0F_0F0F_0F0F, 3'd6, 1, 1'b0);
        run_to_idle(50, 0, "restart");
        check_result("restart", 1, 16);
    endtask

    task automatic test_start_stop_same();
        begin_run(24, 0, 0, 64'h1111_2222_3333_4444, 3'd0, 1, 1'b1);
        run_to_idle(50, 0, "startstop");
        check_result("startstop", 1, 24);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        axis_m_ready = 1'b1;
        cfg_frame_len = '0;
        cfg_count = '0;
        cfg_gap = '0;
        cfg_header = '0;
        cfg_id = '0;
        test_reset();
        test_back_to_back();
        test_keep_len();
        test_backpressure();
        test_stop_gap();
        test_reset_mid();
        test_start_stop_same();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_generator.md
FRAME_GENERATOR -- requirements
Module: frame_generator

Interface
REQ-001 Parameter DATA_WIDTH, default 64, AXIS data width in bits; only 64 is supported.
REQ-002 Parameter ID_WIDTH, default 3, AXIS TID width.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ready  out  1  high when idle and able to accept start.
REQ-006 start  in  1  one-cycle pulse; begins a run when ready=1.
REQ-007 stop  in  1  one-cycle pulse; ends a run at the next frame boundary.
REQ-008 result  out  128  {frames_sent[63:0], bytes_sent[63:0]}.
REQ-009 cfg_frame_len  in  16  frame length in bytes; sampled at start.
REQ-010 cfg_count  in  32  frames per run; 0 = unlimited; sampled at start.
REQ-011 cfg_gap  in  16  idle cycles between frames; sampled at start.
REQ-012 cfg_header  in  64  beat-0 payload; sampled at start.
REQ-013 cfg_id  in  ID_WIDTH  TID for every frame; sampled at start.
REQ-014 axis_m_data/keep/last/user/id/valid  out  DATA_WIDTH/DATA_WIDTH/8/1/DATA_WIDTH/8/ID_WIDTH/1  AXIS master.
REQ-015 axis_m_ready  in  1  AXIS sink backpressure.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, GAP; ready=1 only in IDLE.
REQ-017 start in IDLE SHALL latch cfg_*, clear result, clear the sequence and timestamp counters, and enter SEND next cycle; start outside IDLE is ignored.
REQ-018 Effective length L = max(cfg_frame_len, 16); beats N = ceil(L/8).
REQ-019 Beat 0 data SHALL be the latched cfg_header.
REQ-020 Beat 1 data SHALL be {seq[31:0], ts[31:0]}, where seq is the frame index from 0 and ts is the 32-bit run cycle counter value captured in the cycle beat 0 is first presented.
REQ-021 Beat k>=2 data SHALL be {seq[31:0], k[31:0]}.
REQ-022 keep SHALL be all-ones except on the last beat, where it is (1<<r)-1 with r = L mod 8, or all-ones when r=0.
REQ-023 last SHALL be 1 only on beat N-1; axis_m_user SHALL be 0; axis_m_id SHALL equal the latched cfg_id.
REQ-024 Once valid is asserted, valid and all payload signals SHALL stay stable until the cycle where valid and axis_m_ready are both high.
REQ-025 In SEND, valid SHALL be continuously high; beats advance only on handshake, so a sink holding ready=1 sees one beat per cycle.
REQ-026 On the last-beat handshake: frames_sent += 1, bytes_sent += L, seq += 1, all in that same cycle.
REQ-027 After the last beat: enter IDLE if stop is pending or frames_sent reaches cfg_count (cfg_count != 0); otherwise enter GAP if cfg_gap > 0, else enter SEND with no bubble.
REQ-028 GAP SHALL hold valid=0 for exactly cfg_gap cycles, then enter SEND; a stop during GAP enters IDLE next cycle.
REQ-029 A stop during SEND SHALL be latched as pending; frames are never truncated.
REQ-030 A stop in IDLE is ignored; a start and stop in the same IDLE cycle start the run with stop pending, so exactly one frame is sent.
REQ-031 result SHALL hold its final value in IDLE until the next accepted start.
REQ-032 The 64-bit counters wrap modulo 2^64; seq and ts wrap modulo 2^32.

Reset
REQ-033 rst SHALL force IDLE, ready=1, axis_m_valid=0, axis_m_last=0, axis_m_data/keep/user/id=0, result=0, and clear all counters and pending flags.
REQ-034 rst mid-frame SHALL abort the frame immediately, without completing it; the sink must tolerate the missing last beat.

Structure
REQ-035 The shared package SHALL hold the state encoding, MIN_FRAME_LEN=16, and the result field offsets, for use by this block and by the checker side.
REQ-036 The block SHALL be a single module with no sub-modules; the beat/keep computation is inline logic.

Verification
REQ-037 L=64, count=2, gap=0, sink ready=1: 16 consecutive valid beats; last on beats 7 and 15; seq 0 then 1; result={2,128}.
REQ-038 L=61, count=1: 8 beats; last-beat keep=8'h1F; bytes_sent=61; cfg_frame_len=10 gives L=16, 2 beats, keep=8'hFF.
REQ-039 L=64, count=1, axis_m_ready toggled randomly: all beats unchanged while stalled, in order, with none dropped or duplicated.
REQ-040 count=0, gap=3, stop pulsed mid-frame 5: frame 5 completes; idle runs of exactly 3 cycles between frames; ready=1 after; frames_sent=6.
REQ-041 rst asserted at beat 3: next cycle valid=0, ready=1, result=0; a subsequent start begins again at seq 0.
